// File: rtl/dircc_mbox_pkg.sv
// Shared register map and STATUS layout for the DiRCC HPS mailbox.
// Reg offsets, STATUS bit positions and a helper that assembles the STATUS word.
package dircc_mbox_pkg;

    typedef enum logic [1:0] {
        REG_TX_DATA = 2'd0,
        REG_RX_DATA = 2'd1,
        REG_STATUS  = 2'd2,
        REG_IRQ_EN  = 2'd3
    } reg_off_e;

    localparam int ST_TX_FULL      = 0;
    localparam int ST_RX_NONEMPTY  = 1;
    localparam int ST_OVF          = 2;
    localparam int ST_UDF          = 3;
    localparam int ST_TX_LEVEL_LSB = 8;
    localparam int ST_RX_LEVEL_LSB = 16;
    localparam int LEVEL_FIELD_W   = 8;

    typedef logic [LEVEL_FIELD_W-1:0] level_field_t;

    function automatic logic [31:0] pack_status(
        input logic         tx_full,
        input logic         rx_nonempty,
        input logic         ovf,
        input logic         udf,
        input level_field_t tx_level,
        input level_field_t rx_level
    );
        logic [31:0] s;
        s = '0;
        s[ST_TX_FULL]                            = tx_full;
        s[ST_RX_NONEMPTY]                        = rx_nonempty;
        s[ST_OVF]                                = ovf;
        s[ST_UDF]                                = udf;
        s[ST_TX_LEVEL_LSB +: LEVEL_FIELD_W]      = tx_level;
        s[ST_RX_LEVEL_LSB +: LEVEL_FIELD_W]      = rx_level;
        return s;
    endfunction

endpackage

// File: rtl/dircc_hps_mailbox_if.sv
// Avalon-MM slave bus of the mailbox: fixed read latency 1, no waitrequest.
interface dircc_hps_mailbox_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] avs_address;
    logic                  avs_read;
    logic                  avs_write;
    logic [DATA_WIDTH-1:0] avs_writedata;
    logic [DATA_WIDTH-1:0] avs_readdata;
    logic                  avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/dircc_mbox_fifo.sv
// Synchronous first-word-fall-through FIFO; head is always visible on data_o.
// A push while full is accepted only if a pop happens in the same cycle.
module dircc_mbox_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [LVL_W-1:0]      level_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Pop on empty is ignored, so a push into an empty FIFO never bypasses.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop_ok) level_d = level_q + LVL_W'(1);
        if (pop_ok && !push_ok) level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/dircc_hps_mailbox.sv
// HPS<->fabric mailbox: NUM_CHANNELS channels, each with a TX and RX FIFO,
// sticky ovf/udf flags, an irq enable and a registered level interrupt.
module dircc_hps_mailbox
    import dircc_mbox_pkg::*;
#(
    parameter int NUM_CHANNELS = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                             clk_clk,
    input  logic                             reset_reset,
    dircc_hps_mailbox_if.slave               avs,
    output logic [NUM_CHANNELS-1:0]          tx_valid,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] tx_data,
    input  logic [NUM_CHANNELS-1:0]          tx_ready,
    input  logic [NUM_CHANNELS-1:0]          rx_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] rx_data,
    output logic [NUM_CHANNELS-1:0]          rx_ready,
    output logic [NUM_CHANNELS-1:0]          irq
);
    localparam int ADDR_WIDTH = $clog2(NUM_CHANNELS) + 2;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    reg_off_e              reg_sel;
    logic [ADDR_WIDTH-1:0] chan_addr;
    logic [DATA_WIDTH-1:0] ch_rdata [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0] rdata_d, readdata_q;
    logic                  readdatavalid_q;
    logic                  unused_wdata;

    assign reg_sel      = reg_off_e'(avs.avs_address[1:0]);
    assign chan_addr    = avs.avs_address >> 2;
    assign unused_wdata = ^avs.avs_writedata;

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
        logic                  chan_hit;
        logic                  wr_tx, rd_rx, wr_st, wr_ie;
        logic                  tx_full, tx_empty, tx_pop;
        logic                  rx_full, rx_empty, rx_push;
        logic [LVL_W-1:0]      tx_level, rx_level;
        logic [DATA_WIDTH-1:0] tx_head, rx_head, status_w, rdata_c;
        logic                  ovf_q, ovf_d, udf_q, udf_d;
        logic                  irq_en_q, irq_en_d, irq_q, irq_d;

        assign chan_hit = (chan_addr == ADDR_WIDTH'(gi));
        assign wr_tx    = avs.avs_write && chan_hit && (reg_sel == REG_TX_DATA);
        assign wr_st    = avs.avs_write && chan_hit && (reg_sel == REG_STATUS);
        assign wr_ie    = avs.avs_write && chan_hit && (reg_sel == REG_IRQ_EN);
        assign rd_rx    = avs.avs_read  && chan_hit && (reg_sel == REG_RX_DATA);

        assign tx_pop   = tx_ready[gi] && !tx_empty;
        // RX never takes a word while full, even if the host pops that cycle.
        assign rx_push  = rx_valid[gi] && !rx_full;

        dircc_mbox_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
            .clk(clk_clk), .srst(reset_reset),
            .push_i(wr_tx), .pop_i(tx_pop), .data_i(avs.avs_writedata),
            .data_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .level_o(tx_level)
        );

        dircc_mbox_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
            .clk(clk_clk), .srst(reset_reset),
            .push_i(rx_push), .pop_i(rd_rx), .data_i(rx_data[gi*DATA_WIDTH +: DATA_WIDTH]),
            .data_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .level_o(rx_level)
        );

        assign tx_valid[gi]                           = !tx_empty;
        assign tx_data[gi*DATA_WIDTH +: DATA_WIDTH]   = tx_head;
        assign rx_ready[gi]                           = !rx_full;
        assign irq[gi]                                = irq_q;

        // Clear is applied first so a same-cycle set event wins.
        always_comb begin
            ovf_d    = ovf_q;
            udf_d    = udf_q;
            irq_en_d = irq_en_q;
            if (wr_st) begin
                ovf_d = ovf_q & ~avs.avs_writedata[ST_OVF];
                udf_d = udf_q & ~avs.avs_writedata[ST_UDF];
            end
            if (wr_tx && tx_full && !tx_pop) ovf_d = 1'b1;
            if (rd_rx && rx_empty)           udf_d = 1'b1;
            if (wr_ie) irq_en_d = avs.avs_writedata[0];
            irq_d = irq_en_q && !rx_empty;
        end

        always_ff @(posedge clk_clk) begin
            if (reset_reset) begin
                ovf_q    <= 1'b0;
                udf_q    <= 1'b0;
                irq_en_q <= 1'b0;
                irq_q    <= 1'b0;
            end else begin
                ovf_q    <= ovf_d;
                udf_q    <= udf_d;
                irq_en_q <= irq_en_d;
                irq_q    <= irq_d;
            end
        end

        assign status_w = DATA_WIDTH'(pack_status(tx_full, !rx_empty, ovf_q, udf_q,
                                                  LEVEL_FIELD_W'(tx_level),
                                                  LEVEL_FIELD_W'(rx_level)));

        always_comb begin
            rdata_c = '0;
            if (avs.avs_read && chan_hit) begin
                case (reg_sel)
                    REG_RX_DATA: rdata_c = rx_empty ? '0 : rx_head;
                    REG_STATUS:  rdata_c = status_w;
                    REG_IRQ_EN:  rdata_c = DATA_WIDTH'(irq_en_q);
                    default:     rdata_c = '0;
                endcase
            end
        end

        assign ch_rdata[gi] = rdata_c;
    end

    // Out-of-range channels match no slot, so they read as zero.
    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) rdata_d = rdata_d | ch_rdata[i];
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            readdata_q      <= rdata_d;
            readdatavalid_q <= avs.avs_read;
        end
    end

    assign avs.avs_readdata      = readdata_q;
    assign avs.avs_readdatavalid = readdatavalid_q;

endmodule
